// File: rtl/gt_loopback_pkg.sv
// Shared constants for the GT loopback controller: legal LOOPBACK codes,
// FSM state encoding and a legality helper.
package gt_loopback_pkg;

   localparam logic [2:0] LB_NORMAL = 3'b000;
   localparam logic [2:0] LB_NE_PCS = 3'b001;
   localparam logic [2:0] LB_NE_PMA = 3'b010;
   localparam logic [2:0] LB_FE_PMA = 3'b100;
   localparam logic [2:0] LB_FE_PCS = 3'b110;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_RESET  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_DONE   = 3'd4
   } lb_state_e;

   function automatic logic lb_is_legal(input logic [2:0] code);
      logic ok;
      case (code)
         LB_NORMAL, LB_NE_PCS, LB_NE_PMA, LB_FE_PMA, LB_FE_PCS: ok = 1'b1;
         default:                                               ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/loopback_mode_sync.sv
// Two-flop synchroniser for the asynchronous mode request followed by a
// debouncer: stable_mode takes a value only after DEBOUNCE_CYC consecutive
// identical synchronised samples.
module loopback_mode_sync
   import gt_loopback_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1000,
   parameter int CNT_W        = $clog2(DEBOUNCE_CYC + 1)
) (
   input  logic       clk_50m,
   input  logic       rst,
   input  logic [2:0] loopback_mode,
   output logic [2:0] stable_mode
);

   localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYC);

   logic [2:0]       sync1_q, sync2_q;
   logic [2:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       stable_q, stable_d;

   // Run-length of identical samples, saturating at DB_MAX so it never wraps.
   always_comb begin
      cand_d   = sync2_q;
      stable_d = stable_q;
      if (sync2_q != cand_q) begin
         cnt_d = CNT_W'(1);
      end else if (cnt_q == DB_MAX) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (cnt_d == DB_MAX) begin
         stable_d = sync2_q;
      end
   end

   // Synchroniser and debounce registers.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         sync1_q  <= LB_NORMAL;
         sync2_q  <= LB_NORMAL;
         cand_q   <= LB_NORMAL;
         cnt_q    <= '0;
         stable_q <= LB_NORMAL;
      end else begin
         sync1_q  <= loopback_mode;
         sync2_q  <= sync1_q;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_mode = stable_q;

endmodule

// File: rtl/gt_loopback_ctrl_multi.sv
// Multi-lane GT loopback controller: applies a debounced loopback code to the
// masked lanes, pulses their GT reset, waits for settling, then signals done.
//
//   state  | meaning
//   IDLE   | waiting for a legal stable code different from applied_mode
//   APPLY  | latch lane mask, write code into masked lanes (1 cycle)
//   RESET  | loopback_rst = mask for RST_CYC cycles
//   SETTLE | wait SETTLE_CYC cycles with reset released
//   DONE   | done pulse (1 cycle)
module gt_loopback_ctrl_multi
   import gt_loopback_pkg::*;
#(
   parameter int LANES        = 4,
   parameter int DEBOUNCE_CYC = 1000,
   parameter int RST_CYC      = 50000,
   parameter int SETTLE_CYC   = 5000
) (
   input  logic               clk_50m,
   input  logic               rst,
   input  logic [2:0]         loopback_mode,
   input  logic [LANES-1:0]   lane_mask,
   output logic [3*LANES-1:0] loopback_in,
   output logic [LANES-1:0]   loopback_rst,
   output logic               busy,
   output logic               done,
   output logic               err_illegal,
   output logic [2:0]         applied_mode
);

   localparam int MAX_RS  = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
   localparam int MAX_CYC = (MAX_RS > DEBOUNCE_CYC) ? MAX_RS : DEBOUNCE_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   logic [2:0]         stable_mode;
   lb_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [LANES-1:0]   mask_q, mask_d;
   logic [2:0]         target_q, target_d;
   logic [3*LANES-1:0] lb_in_q, lb_in_d;
   logic [LANES-1:0]   lb_rst_q, lb_rst_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [2:0]         applied_q, applied_d;
   logic               rep_valid_q, rep_valid_d;
   logic [2:0]         rep_val_q, rep_val_d;

   loopback_mode_sync #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
   ) u_sync (
      .clk_50m       (clk_50m),
      .rst           (rst),
      .loopback_mode (loopback_mode),
      .stable_mode   (stable_mode)
   );

   // Next-state and next-output logic; outputs are computed one edge early so
   // every port comes straight from a flop.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mask_d      = mask_q;
      target_d    = target_q;
      lb_in_d     = lb_in_q;
      lb_rst_d    = '0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      applied_d   = applied_q;
      // An illegal code is reported once per stable episode; any change of
      // stable_mode re-arms the report.
      rep_valid_d = rep_valid_q && (stable_mode == rep_val_q);
      rep_val_d   = rep_val_q;
      case (state_q)
         ST_IDLE: begin
            if (stable_mode != applied_q) begin
               if (lb_is_legal(stable_mode)) begin
                  // Capture the code now so a late change cannot leak into APPLY.
                  state_d  = ST_APPLY;
                  target_d = stable_mode;
                  cnt_d    = '0;
               end else if (!rep_valid_d) begin
                  err_d       = 1'b1;
                  rep_valid_d = 1'b1;
                  rep_val_d   = stable_mode;
               end
            end
         end
         ST_APPLY: begin
            mask_d    = lane_mask;
            applied_d = target_q;
            for (int n = 0; n < LANES; n++) begin
               if (lane_mask[n]) lb_in_d[3*n +: 3] = target_q;
            end
            cnt_d = '0;
            if (lane_mask == '0) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               state_d  = ST_RESET;
               lb_rst_d = lane_mask;
            end
         end
         ST_RESET: begin
            if (cnt_q == RST_LAST) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
               lb_rst_d = mask_q;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // FSM, counter and registered outputs.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         mask_q      <= '0;
         target_q    <= LB_NORMAL;
         lb_in_q     <= '0;
         lb_rst_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         applied_q   <= LB_NORMAL;
         rep_valid_q <= 1'b0;
         rep_val_q   <= LB_NORMAL;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mask_q      <= mask_d;
         target_q    <= target_d;
         lb_in_q     <= lb_in_d;
         lb_rst_q    <= lb_rst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         applied_q   <= applied_d;
         rep_valid_q <= rep_valid_d;
         rep_val_q   <= rep_val_d;
      end
   end

   assign loopback_in  = lb_in_q;
   assign loopback_rst = lb_rst_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err_illegal  = err_q;
   assign applied_mode = applied_q;

endmodule

// File: tb/tb_gt_loopback_ctrl_multi.sv
// Bench for gt_loopback_ctrl_multi: a timeline model (sequence age relative
// to its APPLY cycle) is checked against the DUT on every cycle, with
// directed scenarios pinned by literal expectations and a randomized tail.
module tb_gt_loopback_ctrl_multi;

   localparam int LANES = 4;
   localparam int DB    = 4;
   localparam int RC    = 10;
   localparam int SC    = 5;

   logic               clk_50m = 1'b0;
   logic               rst = 1'b1;
   logic [2:0]         loopback_mode = 3'b000;
   logic [LANES-1:0]   lane_mask = '0;
   logic [3*LANES-1:0] loopback_in;
   logic [LANES-1:0]   loopback_rst;
   logic               busy, done, err_illegal;
   logic [2:0]         applied_mode;

   always #10 clk_50m = ~clk_50m;

   gt_loopback_ctrl_multi #(
      .LANES(LANES), .DEBOUNCE_CYC(DB), .RST_CYC(RC), .SETTLE_CYC(SC)
   ) dut (
      .clk_50m      (clk_50m),
      .rst          (rst),
      .loopback_mode(loopback_mode),
      .lane_mask    (lane_mask),
      .loopback_in  (loopback_in),
      .loopback_rst (loopback_rst),
      .busy         (busy),
      .done         (done),
      .err_illegal  (err_illegal),
      .applied_mode (applied_mode)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [2:0]       m_sy1, m_sy2, m_stable, m_applied, m_target;
   logic [2:0]       m_hist[$];
   logic [2:0]       m_field[LANES];
   logic [LANES-1:0] m_mask;
   bit               m_active, m_err, m_reported, m_eq;
   bit               m_valid = 0;
   int               m_age;

   function automatic bit legal(input logic [2:0] c);
      return (c == 3'd0) || (c == 3'd1) || (c == 3'd2) || (c == 3'd4) || (c == 3'd6);
   endfunction

   // Total sequence length in cycles, APPLY through DONE.
   function automatic int seq_len(input logic [LANES-1:0] msk);
      return (msk == '0) ? 2 : RC + SC + 2;
   endfunction

   always @(posedge clk_50m) begin
      if (rst) begin
         m_sy1 = 0; m_sy2 = 0; m_stable = 0; m_applied = 0; m_target = 0;
         m_hist.delete();
         for (int i = 0; i < LANES; i++) m_field[i] = 0;
         m_mask = 0; m_active = 0; m_err = 0; m_reported = 0; m_age = 0;
      end else begin
         m_err = 0;
         if (!m_active) begin
            if (m_stable != m_applied && legal(m_stable)) begin
               m_active = 1; m_age = 0; m_target = m_stable;
            end else if (!legal(m_stable) && !m_reported) begin
               m_err = 1; m_reported = 1;
            end
         end else begin
            m_age++;
            if (m_age == 1) begin
               m_mask    = lane_mask;
               m_applied = m_target;
               for (int i = 0; i < LANES; i++) if (lane_mask[i]) m_field[i] = m_target;
            end
            if (m_age >= seq_len(m_mask)) m_active = 0;
         end
         m_hist.push_back(m_sy2);
         if (m_hist.size() > DB) void'(m_hist.pop_front());
         m_sy2 = m_sy1;
         m_sy1 = loopback_mode;
         if (m_hist.size() == DB) begin
            m_eq = 1;
            foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) m_eq = 0;
            if (m_eq) begin
               if (m_hist[0] != m_stable) m_reported = 0;
               m_stable = m_hist[0];
            end
         end
      end
      m_valid = 1;
   end

   // ---------------- per-cycle compare and event counters ----------------
   int rst_cyc = 0, done_cnt = 0, err_cnt = 0, busy_seen = 0;
   logic [3*LANES-1:0] e_in;
   logic [LANES-1:0]   e_rst;
   bit                 e_done;

   always @(negedge clk_50m) begin
      if (m_valid) begin
         for (int i = 0; i < LANES; i++) e_in[3*i +: 3] = m_field[i];
         e_rst  = (m_active && m_age >= 1 && m_age <= RC) ? m_mask : '0;
         e_done = m_active && m_age >= 1 && (m_age == seq_len(m_mask) - 1);
         chk("loopback_in",  32'(loopback_in),  32'(e_in));
         chk("loopback_rst", 32'(loopback_rst), 32'(e_rst));
         chk("busy",         32'(busy),         32'(m_active));
         chk("done",         32'(done),         32'(e_done));
         chk("err_illegal",  32'(err_illegal),  32'(m_err));
         chk("applied_mode", 32'(applied_mode), 32'(m_applied));
         if (loopback_rst != '0) rst_cyc++;
         if (done) done_cnt++;
         if (err_illegal) err_cnt++;
         if (busy) busy_seen++;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk_50m);
   endtask

   task automatic clr();
      rst_cyc = 0; done_cnt = 0; err_cnt = 0; busy_seen = 0;
   endtask

   task automatic wait_lrst(input string nm);
      int k = 0;
      while (loopback_rst == '0 && k < 60) begin
         @(negedge clk_50m);
         k++;
      end
      chk(nm, 32'(k < 60), 32'd1);
   endtask

   initial begin
      // Reset state
      step(3);
      rst = 0;
      chk("rst_loopback_in", 32'(loopback_in), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_applied", 32'(applied_mode), 32'h0);
      step(10);

      // Basic change on all lanes
      clr(); lane_mask = 4'b1111; loopback_mode = 3'b010; step(40);
      chk("basic_in", 32'(loopback_in), 32'h492);
      chk("basic_applied", 32'(applied_mode), 32'h2);
      chk("basic_rst_cyc", 32'(rst_cyc), 32'd10);
      chk("basic_done_cnt", 32'(done_cnt), 32'd1);

      // Partial mask
      clr(); lane_mask = 4'b0101; loopback_mode = 3'b001; step(40);
      chk("partial_in", 32'(loopback_in), 32'h451);
      chk("partial_rst_cyc", 32'(rst_cyc), 32'd10);
      chk("partial_applied", 32'(applied_mode), 32'h1);

      // Glitch shorter than the debounce window, then a held change
      clr(); loopback_mode = 3'b100; step(3); loopback_mode = 3'b001; step(20);
      chk("glitch_busy", 32'(busy_seen), 32'd0);
      chk("glitch_applied", 32'(applied_mode), 32'h1);
      clr(); loopback_mode = 3'b100; step(40);
      chk("held_applied", 32'(applied_mode), 32'h4);
      chk("held_done_cnt", 32'(done_cnt), 32'd1);

      // Illegal code then a legal one
      clr(); loopback_mode = 3'b011; step(30);
      chk("illegal_err_cnt", 32'(err_cnt), 32'd1);
      chk("illegal_busy", 32'(busy_seen), 32'd0);
      chk("illegal_applied", 32'(applied_mode), 32'h4);
      clr(); loopback_mode = 3'b110; step(40);
      chk("fepcs_applied", 32'(applied_mode), 32'h6);
      chk("fepcs_done_cnt", 32'(done_cnt), 32'd1);

      // Change during a sequence chains a second one
      clr(); lane_mask = 4'b1111; loopback_mode = 3'b010;
      wait_lrst("chain_wait");
      step(2); loopback_mode = 3'b000; step(80);
      chk("chain_done_cnt", 32'(done_cnt), 32'd2);
      chk("chain_applied", 32'(applied_mode), 32'h0);
      chk("chain_in", 32'(loopback_in), 32'h0);

      // Reset mid-sequence aborts, then a fresh sequence runs
      loopback_mode = 3'b010;
      wait_lrst("abort_wait");
      step(4); rst = 1; step(1);
      chk("abort_lrst", 32'(loopback_rst), 32'h0);
      chk("abort_in", 32'(loopback_in), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      rst = 0; clr(); step(40);
      chk("rerun_done_cnt", 32'(done_cnt), 32'd1);
      chk("rerun_applied", 32'(applied_mode), 32'h2);
      chk("rerun_rst_cyc", 32'(rst_cyc), 32'd10);

      // Empty mask goes straight to DONE
      clr(); lane_mask = 4'b0000; loopback_mode = 3'b001; step(30);
      chk("nomask_done_cnt", 32'(done_cnt), 32'd1);
      chk("nomask_rst_cyc", 32'(rst_cyc), 32'd0);
      chk("nomask_applied", 32'(applied_mode), 32'h1);
      chk("nomask_in", 32'(loopback_in), 32'h492);

      // Randomized tail, checked by the per-cycle model compare
      for (int it = 0; it < 250; it++) begin
         if ($urandom_range(0, 3) == 0) loopback_mode = 3'($urandom_range(0, 7));
         else begin
            case ($urandom_range(0, 4))
               0: loopback_mode = 3'b000;
               1: loopback_mode = 3'b001;
               2: loopback_mode = 3'b010;
               3: loopback_mode = 3'b100;
               default: loopback_mode = 3'b110;
            endcase
         end
         lane_mask = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) begin
            rst = 1; step(1); rst = 0;
         end
         step($urandom_range(1, 30));
      end
      step(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gt_loopback_ctrl_multi.md
GT_LOOPBACK_CTRL_MULTI -- requirements
Module: gt_loopback_ctrl_multi

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- LANES, 4, number of GT lanes controlled (1..8).
- DEBOUNCE_CYC, 1000, consecutive stable cycles needed to accept a new mode request.
- RST_CYC, 50000, loopback_rst assertion length in clk_50m cycles (1 ms at 50 MHz).
- SETTLE_CYC, 5000, wait after reset release before completion (100 us).
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk_50m, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- loopback_mode, in, 3, requested GT LOOPBACK code; asynchronous source.
- lane_mask, in, LANES, lanes affected by the next change.
- loopback_in, out, 3*LANES, per-lane GT LOOPBACK code; lane n occupies bits [3n+2:3n].
- loopback_rst, out, LANES, per-lane GT reset request.
- busy, out, 1, change sequence in progress.
- done, out, 1, one-cycle completion pulse.
- err_illegal, out, 1, one-cycle pulse on an accepted illegal code.
- applied_mode, out, 3, last legally applied code.
REQ-003 There SHALL be one clock, clk_50m, and one reset, rst, which is synchronous and active-high; every register SHALL be clocked by clk_50m only.

Function
REQ-004 loopback_mode SHALL pass through a 2-flop synchroniser before any use.
REQ-005 The synchronised value SHALL become stable_mode only after it holds unchanged for DEBOUNCE_CYC consecutive cycles; any change SHALL restart the count.
REQ-006 The legal codes SHALL be 000 (normal), 001 (near-end PCS), 010 (near-end PMA), 100 (far-end PMA) and 110 (far-end PCS); all other codes SHALL be illegal.
REQ-007 The FSM SHALL have the states IDLE, APPLY, RESET, SETTLE and DONE.
REQ-008 In IDLE, when stable_mode differs from applied_mode and is legal, the FSM SHALL go to APPLY on the next cycle.
REQ-009 In IDLE, when a newly stable illegal code appears, err_illegal SHALL pulse exactly once and the FSM SHALL remain in IDLE; the same illegal value SHALL NOT re-pulse until stable_mode changes.
REQ-010 APPLY SHALL last 1 cycle and SHALL perform the following actions:
- latch lane_mask into mask_q;
- write stable_mode into the loopback_in field of every lane set in mask_q;
- leave the fields of unmasked lanes unchanged;
- set applied_mode to stable_mode.
REQ-011 In RESET, loopback_rst[n] SHALL equal mask_q[n] for exactly RST_CYC cycles, after which the FSM SHALL enter SETTLE.
REQ-012 SETTLE SHALL last exactly SETTLE_CYC cycles with loopback_rst at 0, after which the FSM SHALL enter DONE.
REQ-013 DONE SHALL last 1 cycle with done=1, after which the FSM SHALL return to IDLE.
REQ-014 busy SHALL be 1 in APPLY, RESET, SETTLE and DONE, and 0 in IDLE.
REQ-015 If mask_q is all zero, APPLY SHALL go directly to DONE, with no loopback_rst assertion and applied_mode still updated.
REQ-016 Mode or mask changes while busy SHALL NOT alter the sequence in progress; the debouncer SHALL keep running, and IDLE SHALL re-evaluate stable_mode against applied_mode, so back-to-back changes chain with one IDLE cycle between them.
REQ-017 Counters SHALL be $clog2(max(RST_CYC, SETTLE_CYC, DEBOUNCE_CYC)+1) bits wide, SHALL clear on every state entry, and SHALL never wrap.

Reset
REQ-018 On rst=1, all of the following SHALL be set on the next clock edge:
- the FSM to IDLE;
- loopback_in to all zeros;
- loopback_rst to 0;
- busy, done and err_illegal to 0;
- applied_mode to 000;
- all counters to 0;
- stable_mode to 000.
REQ-019 Reset asserted mid-sequence SHALL abort the sequence immediately; loopback_rst SHALL deassert in the same edge.
REQ-020 After reset, a synchronised input held at a non-000 legal code SHALL start a change once it has been debounced.

Structure
REQ-021 The legal-code constants (LB_NORMAL, LB_NE_PCS, LB_NE_PMA, LB_FE_PMA, LB_FE_PCS) and the FSM state encoding SHALL reside in the shared package gt_loopback_pkg.
REQ-022 The synchroniser and debouncer SHALL be one sub-module, loopback_mode_sync, parameterised by DEBOUNCE_CYC, with a 3-bit output stable_mode.
REQ-023 All outputs SHALL be driven directly from registers.

Verification (LANES=4, DEBOUNCE_CYC=4, RST_CYC=10, SETTLE_CYC=5)
REQ-024 Basic change: with mask=1111, set mode=010 -> loopback_in=0x492 (all lanes 010); loopback_rst=1111 for 10 cycles; done pulses 5 cycles later; applied_mode=010.
REQ-025 Partial mask: with mask=0101, set mode=001 -> lanes 0 and 2 become 001, lanes 1 and 3 keep their previous value; loopback_rst=0101 for 10 cycles.
REQ-026 Glitch: a 3-cycle pulse to 100 -> no busy, no change; the same pulse held 8 cycles -> sequence runs and applied_mode=100.
REQ-027 Illegal code: set mode=011 -> exactly one err_illegal pulse, busy stays 0 and outputs are unchanged; then mode=110 -> normal sequence.
REQ-028 Change during sequence: mode=010, then mode=000 at RESET cycle 3 -> the first sequence completes, one IDLE cycle follows, a second sequence applies 000, and done pulses twice in total.
REQ-029 Abort: assert rst at RESET cycle 5 -> loopback_rst=0, loopback_in=0 and busy=0 the next cycle; after release with mode held at 010 -> a fresh full sequence runs.
